// File: rtl/riscv_pkg.sv
// Shared types and constants for the multicycle RV32I control unit.
// Holds the FSM state set, the opcode/ALU codes and the per-state Moore control table.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } mc_state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input mc_state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_update  = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: c.reg_write = 1'b1;
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus instruction function fields to the 3-bit ALU operation code.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type sub from addi, which shares funct7b5 with imm[10]
                    3'b000:  ALUControl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I datapath, with PCWrite, ImmSrc and the ALU decoder.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       IllegalInstr
);

    mc_state_t state;
    mc_state_t next_state;
    ctrl_t     ctrl_q;
    ctrl_t     ctrl;
    logic      known_op;

    always_comb begin
        known_op = 1'b1;
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: known_op = 1'b1;
            default:                                  known_op = 1'b0;
        endcase
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECUTER;
                    OP_I:         next_state = S_EXECUTEI;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = S_MEMWB;
            S_EXECUTER: next_state = S_ALUWB;
            S_EXECUTEI: next_state = S_ALUWB;
            S_JAL:      next_state = S_ALUWB;
            default:    next_state = S_FETCH;
        endcase
    end

    // Control bits are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            ctrl_q <= state_ctrl(S_FETCH);
        end else begin
            state  <= next_state;
            ctrl_q <= state_ctrl(next_state);
        end
    end

    // Reset overrides the current step immediately: fetch selects, every enable off.
    always_comb begin
        ctrl = ctrl_q;
        if (reset) begin
            ctrl           = state_ctrl(S_FETCH);
            ctrl.pc_update = 1'b0;
            ctrl.branch    = 1'b0;
            ctrl.ir_write  = 1'b0;
            ctrl.reg_write = 1'b0;
            ctrl.mem_write = 1'b0;
        end
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite      = ctrl.pc_update | (ctrl.branch & Zero);
    assign AdrSrc       = ctrl.adr_src;
    assign MemWrite     = ctrl.mem_write;
    assign IRWrite      = ctrl.ir_write;
    assign RegWrite     = ctrl.reg_write;
    assign ResultSrc    = ctrl.result_src;
    assign ALUSrcA      = ctrl.alu_src_a;
    assign ALUSrcB      = ctrl.alu_src_b;
    assign IllegalInstr = (state == S_DECODE) && !known_op && !reset;

    alu_decoder u_alu_decoder (
        .ALUOp      (ctrl.alu_op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .ALUControl (ALUControl)
    );

endmodule
